// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Exception-related states only become reachable when CTRL_EXCEPTIONS_EN is defined.
package ctrl_pkg;

  localparam int unsigned RESET_SP        = 227;
  localparam int unsigned EXC_OPCODE_ADDR = 253;
  localparam int unsigned EXC_OVF_ADDR    = 254;

  typedef enum logic [4:0] {
    StReset,
    StFetch,
    StFetchWait,
    StDecode,
    StExecR,
    StWbR,
    StAddi,
    StWbI,
    StMemAddr,
    StLwRead,
    StLwWait,
    StLwWb,
    StSw,
    StBranch,
    StJump,
    StJal,
    StExcOpc,
    StExcOvf,
    StExcRead,
    StExcWait,
    StExcJump
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FunctAdd = 6'h20;
  localparam logic [5:0] FunctSub = 6'h22;
  localparam logic [5:0] FunctAnd = 6'h24;

  localparam logic [2:0] AluLoadA = 3'd0;
  localparam logic [2:0] AluAdd   = 3'd1;
  localparam logic [2:0] AluSub   = 3'd2;
  localparam logic [2:0] AluAnd   = 3'd3;

  localparam logic [1:0] IordPc     = 2'd0;
  localparam logic [1:0] IordAluOut = 2'd1;
  localparam logic [1:0] IordVector = 2'd2;

  localparam logic [1:0] ExcOpcode   = 2'd0;
  localparam logic [1:0] ExcOverflow = 2'd1;

  localparam logic [1:0] SrcAPc  = 2'd0;
  localparam logic [1:0] SrcAReg = 2'd1;

  localparam logic [1:0] SrcBReg   = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBImmSh = 2'd3;

  localparam logic [2:0] PcAlu    = 3'd0;
  localparam logic [2:0] PcAluOut = 3'd1;
  localparam logic [2:0] PcJump   = 3'd2;
  localparam logic [2:0] PcMdr    = 3'd3;

  localparam logic [2:0] DstRt = 3'd0;
  localparam logic [2:0] DstRd = 3'd1;
  localparam logic [2:0] DstSp = 3'd2;
  localparam logic [2:0] DstRa = 3'd3;

  localparam logic [3:0] RegSrcAluOut  = 4'd0;
  localparam logic [3:0] RegSrcMdr     = 4'd1;
  localparam logic [3:0] RegSrcPc      = 4'd2;
  localparam logic [3:0] RegSrcResetSp = 4'd3;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct dispatch used by the DECODE state.
// With CTRL_EXCEPTIONS_EN undefined, unknown encodings fall back to FETCH as a NOP.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_e     next_state
);

  state_e invalid_st;

`ifdef CTRL_EXCEPTIONS_EN
  assign invalid_st = StExcOpc;
`else
  assign invalid_st = StFetch;
`endif

  always_comb begin
    next_state = invalid_st;
    case (opcode)
      OpRtype: begin
        if (funct == FunctAdd || funct == FunctSub || funct == FunctAnd) begin
          next_state = StExecR;
        end
      end
      OpAddi:      next_state = StAddi;
      OpLw, OpSw:  next_state = StMemAddr;
      OpBeq, OpBne: next_state = StBranch;
      OpJ:         next_state = StJump;
      OpJal:       next_state = StJal;
      default:     next_state = invalid_st;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle MIPS main control FSM: Moore decode of the state register.
// Define CTRL_EXCEPTIONS_EN to enable the opcode/overflow exception path.
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  output logic       pc_write,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       ab_write,
  output logic       alu_out_write,
  output logic       mdr_write,
  output logic       epc_write,
  output logic [1:0] iord,
  output logic [1:0] excp_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [2:0] pc_source,
  output logic [2:0] reg_dst,
  output logic [3:0] reg_src
);

  state_e state_q, state_d, dispatch;
  logic   arith_r;

  ctrl_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .next_state (dispatch)
  );

  // Only add/sub can trap; "and" never does.
  assign arith_r = (funct == FunctAdd) || (funct == FunctSub);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CTRL_EXCEPTIONS_EN
  logic [1:0] excp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      excp_q <= ExcOpcode;
    end else if (state_d == StExcOpc) begin
      excp_q <= ExcOpcode;
    end else if (state_d == StExcOvf) begin
      excp_q <= ExcOverflow;
    end
  end
`else
  // Overflow has no effect when exceptions are disabled.
  logic unused_overflow;
  assign unused_overflow = overflow ^ arith_r;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:     state_d = StFetch;
      StFetch:     state_d = StFetchWait;
      StFetchWait: state_d = StDecode;
      StDecode:    state_d = dispatch;
`ifdef CTRL_EXCEPTIONS_EN
      StExecR:     state_d = (overflow && arith_r) ? StExcOvf : StWbR;
      StAddi:      state_d = overflow ? StExcOvf : StWbI;
      StExcOpc,
      StExcOvf:    state_d = StExcRead;
      StExcRead:   state_d = StExcWait;
      StExcWait:   state_d = StExcJump;
      StExcJump:   state_d = StFetch;
`else
      StExecR:     state_d = StWbR;
      StAddi:      state_d = StWbI;
`endif
      StWbR:       state_d = StFetch;
      StWbI:       state_d = StFetch;
      StMemAddr:   state_d = (opcode == OpSw) ? StSw : StLwRead;
      StLwRead:    state_d = StLwWait;
      StLwWait:    state_d = StLwWb;
      StLwWb:      state_d = StFetch;
      StSw:        state_d = StFetch;
      StBranch:    state_d = StFetch;
      StJump:      state_d = StFetch;
      StJal:       state_d = StFetch;
      default:     state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    ab_write      = 1'b0;
    alu_out_write = 1'b0;
    mdr_write     = 1'b0;
    epc_write     = 1'b0;
    iord          = IordPc;
    excp_sel      = ExcOpcode;
    alu_src_a     = SrcAPc;
    alu_src_b     = SrcBReg;
    alu_op        = AluLoadA;
    pc_source     = PcAlu;
    reg_dst       = DstRt;
    reg_src       = RegSrcAluOut;
    case (state_q)
      StReset: begin
        reg_write = 1'b1;
        reg_dst   = DstSp;
        reg_src   = RegSrcResetSp;
      end
      StFetch: begin
        alu_src_b = SrcBFour;
        alu_op    = AluAdd;
        pc_write  = 1'b1;
      end
      StFetchWait: ir_write = 1'b1;
      StDecode: begin
        // Branch target precomputed into ALUOut.
        ab_write      = 1'b1;
        alu_out_write = 1'b1;
        alu_src_b     = SrcBImmSh;
        alu_op        = AluAdd;
      end
      StExecR: begin
        alu_out_write = 1'b1;
        alu_src_a     = SrcAReg;
        alu_src_b     = SrcBReg;
        case (funct)
          FunctSub: alu_op = AluSub;
          FunctAnd: alu_op = AluAnd;
          default:  alu_op = AluAdd;
        endcase
      end
      StWbR: begin
        reg_write = 1'b1;
        reg_dst   = DstRd;
      end
      StAddi, StMemAddr: begin
        alu_out_write = 1'b1;
        alu_src_a     = SrcAReg;
        alu_src_b     = SrcBImm;
        alu_op        = AluAdd;
      end
      StWbI: reg_write = 1'b1;
      StLwRead: iord = IordAluOut;
      StLwWait: mdr_write = 1'b1;
      StLwWb: begin
        reg_write = 1'b1;
        reg_src   = RegSrcMdr;
      end
      StSw: begin
        iord      = IordAluOut;
        mem_write = 1'b1;
      end
      StBranch: begin
        alu_src_a = SrcAReg;
        alu_src_b = SrcBReg;
        alu_op    = AluSub;
        pc_source = PcAluOut;
        pc_write  = ((opcode == OpBeq) && zero) || ((opcode == OpBne) && !zero);
      end
      StJump: begin
        pc_source = PcJump;
        pc_write  = 1'b1;
      end
      StJal: begin
        reg_write = 1'b1;
        reg_dst   = DstRa;
        reg_src   = RegSrcPc;
        pc_source = PcJump;
        pc_write  = 1'b1;
      end
`ifdef CTRL_EXCEPTIONS_EN
      StExcOpc, StExcOvf: begin
        // EPC <- PC - 4 (PC was already advanced in FETCH).
        alu_src_b = SrcBFour;
        alu_op    = AluSub;
        epc_write = 1'b1;
        excp_sel  = (state_q == StExcOvf) ? ExcOverflow : ExcOpcode;
      end
      StExcRead: begin
        iord     = IordVector;
        excp_sel = excp_q;
      end
      StExcWait: begin
        mdr_write = 1'b1;
        excp_sel  = excp_q;
      end
      StExcJump: begin
        pc_source = PcMdr;
        pc_write  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected output words are queued and
// compared against the DUT outputs sampled mid-cycle.
module tb_control_unit;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       mdr_write;
    logic       epc_write;
    logic [1:0] iord;
    logic [1:0] excp_sel;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] pc_source;
    logic [2:0] reg_dst;
    logic [3:0] reg_src;
  } cu_out_t;

  typedef enum int {
    TReset, TFetch, TFetchWait, TDecode, TExecR, TWbR, TAddi, TWbI, TMemAddr,
    TLwRead, TLwWait, TLwWb, TSw, TBranch, TJump, TJal,
    TExcOpc, TExcOvf, TExcRead, TExcWait, TExcJump
  } tb_st_e;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       zero;
  logic       pc_write, mem_write, ir_write, reg_write, ab_write;
  logic       alu_out_write, mdr_write, epc_write;
  logic [1:0] iord, excp_sel, alu_src_a, alu_src_b;
  logic [2:0] alu_op, pc_source, reg_dst;
  logic [3:0] reg_src;

  int tests = 0;
  int fails = 0;
  logic [1:0] exc_m = 2'd0;
  cu_out_t sb[$];

  control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .overflow      (overflow),
    .zero          (zero),
    .pc_write      (pc_write),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .ab_write      (ab_write),
    .alu_out_write (alu_out_write),
    .mdr_write     (mdr_write),
    .epc_write     (epc_write),
    .iord          (iord),
    .excp_sel      (excp_sel),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .reg_dst       (reg_dst),
    .reg_src       (reg_src)
  );

  always #5 clk = ~clk;

  // Expected Moore outputs for each state, straight from the control table.
  function automatic cu_out_t exp_out(input tb_st_e s);
    cu_out_t o;
    o = '0;
    case (s)
      TReset:     begin o.reg_write = 1; o.reg_dst = 3'd2; o.reg_src = 4'd3; end
      TFetch:     begin o.alu_src_b = 2'd1; o.alu_op = 3'd1; o.pc_write = 1; end
      TFetchWait: o.ir_write = 1;
      TDecode:    begin o.ab_write = 1; o.alu_out_write = 1; o.alu_src_b = 2'd3;
                        o.alu_op = 3'd1; end
      TExecR:     begin o.alu_out_write = 1; o.alu_src_a = 2'd1;
                        o.alu_op = (funct == 6'h22) ? 3'd2 : (funct == 6'h24) ? 3'd3 : 3'd1;
                  end
      TWbR:       begin o.reg_write = 1; o.reg_dst = 3'd1; end
      TAddi, TMemAddr: begin o.alu_out_write = 1; o.alu_src_a = 2'd1; o.alu_src_b = 2'd2;
                             o.alu_op = 3'd1; end
      TWbI:       o.reg_write = 1;
      TLwRead:    o.iord = 2'd1;
      TLwWait:    o.mdr_write = 1;
      TLwWb:      begin o.reg_write = 1; o.reg_src = 4'd1; end
      TSw:        begin o.iord = 2'd1; o.mem_write = 1; end
      TBranch:    begin o.alu_src_a = 2'd1; o.alu_op = 3'd2; o.pc_source = 3'd1;
                        o.pc_write = ((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero);
                  end
      TJump:      begin o.pc_source = 3'd2; o.pc_write = 1; end
      TJal:       begin o.reg_write = 1; o.reg_dst = 3'd3; o.reg_src = 4'd2;
                        o.pc_source = 3'd2; o.pc_write = 1; end
      TExcOpc:    begin o.alu_src_b = 2'd1; o.alu_op = 3'd2; o.epc_write = 1; end
      TExcOvf:    begin o.alu_src_b = 2'd1; o.alu_op = 3'd2; o.epc_write = 1;
                        o.excp_sel = 2'd1; end
      TExcRead:   begin o.iord = 2'd2; o.excp_sel = exc_m; end
      TExcWait:   begin o.mdr_write = 1; o.excp_sel = exc_m; end
      TExcJump:   begin o.pc_source = 3'd3; o.pc_write = 1; end
      default:    o = '0;
    endcase
    return o;
  endfunction

  // One cycle: queue the expectation, sample mid-cycle, compare, then cross a rising edge.
  task automatic cyc(input tb_st_e s, input string tag);
    cu_out_t got, e;
    sb.push_back(exp_out(s));
    #1;
    got = {pc_write, mem_write, ir_write, reg_write, ab_write, alu_out_write, mdr_write,
           epc_write, iord, excp_sel, alu_src_a, alu_src_b, alu_op, pc_source, reg_dst,
           reg_src};
    e = sb.pop_front();
    tests++;
    assert (got === e) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
    @(negedge clk);
  endtask

  task automatic front(input logic [5:0] o, input logic [5:0] f, input string tag);
    opcode = o;
    funct  = f;
    cyc(TFetch, {tag, "_fetch"});
    cyc(TFetchWait, {tag, "_fwait"});
    cyc(TDecode, {tag, "_decode"});
  endtask

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; overflow = 1'b0; zero = 1'b0;
    @(negedge clk);
    cyc(TReset, "rst_hold");
    reset = 1'b0;
    cyc(TReset, "rst_st");

    front(6'h00, 6'h20, "add");
    cyc(TExecR, "add_exec");
    cyc(TWbR, "add_wb");

    // "and" must not trap even with overflow raised
    overflow = 1'b1;
    front(6'h00, 6'h24, "and_ovf");
    cyc(TExecR, "and_exec");
    cyc(TWbR, "and_wb");
    overflow = 1'b0;

    front(6'h00, 6'h22, "sub");
    cyc(TExecR, "sub_exec");
    cyc(TWbR, "sub_wb");

    front(6'h04, 6'h00, "beq_t");
    zero = 1'b1;
    cyc(TBranch, "beq_taken");
    front(6'h04, 6'h00, "beq_n");
    zero = 1'b0;
    cyc(TBranch, "beq_not");
    front(6'h05, 6'h00, "bne_t");
    cyc(TBranch, "bne_taken");

    front(6'h23, 6'h00, "lw");
    cyc(TMemAddr, "lw_addr");
    cyc(TLwRead, "lw_read");
    cyc(TLwWait, "lw_wait");
    cyc(TLwWb, "lw_wb");

    front(6'h2B, 6'h00, "sw");
    cyc(TMemAddr, "sw_addr");
    cyc(TSw, "sw_store");

    front(6'h08, 6'h00, "addi");
    cyc(TAddi, "addi_exec");
    cyc(TWbI, "addi_wb");

    front(6'h02, 6'h00, "j");
    cyc(TJump, "j_jump");
    front(6'h03, 6'h00, "jal");
    cyc(TJal, "jal_link");

    // Overflow is raised through fetch/decode too, where it must be ignored.
    overflow = 1'b1;
    front(6'h00, 6'h20, "add_ovf");
    cyc(TExecR, "add_ovf_exec");
    overflow = 1'b0;
`ifdef CTRL_EXCEPTIONS_EN
    exc_m = 2'd1;
    cyc(TExcOvf, "ovf_epc");
    cyc(TExcRead, "ovf_read");
    cyc(TExcWait, "ovf_wait");
    cyc(TExcJump, "ovf_jump");
`else
    cyc(TWbR, "ovf_ignored_wb");
`endif

    overflow = 1'b1;
    front(6'h08, 6'h00, "addi_ovf");
    cyc(TAddi, "addi_ovf_exec");
    overflow = 1'b0;
`ifdef CTRL_EXCEPTIONS_EN
    exc_m = 2'd1;
    cyc(TExcOvf, "addi_ovf_epc");
    cyc(TExcRead, "addi_ovf_read");
    cyc(TExcWait, "addi_ovf_wait");
    cyc(TExcJump, "addi_ovf_jump");
`else
    cyc(TWbI, "addi_ovf_ignored_wb");
`endif

    front(6'h3F, 6'h00, "badop");
`ifdef CTRL_EXCEPTIONS_EN
    exc_m = 2'd0;
    cyc(TExcOpc, "badop_epc");
    cyc(TExcRead, "badop_read");
    cyc(TExcWait, "badop_wait");
    cyc(TExcJump, "badop_jump");
`endif

    front(6'h00, 6'h25, "badfn");
`ifdef CTRL_EXCEPTIONS_EN
    exc_m = 2'd0;
    cyc(TExcOpc, "badfn_epc");
    cyc(TExcRead, "badfn_read");
    cyc(TExcWait, "badfn_wait");
    cyc(TExcJump, "badfn_jump");
`endif

    // Reset mid-instruction: LW_WB must never appear.
    front(6'h23, 6'h00, "lw_rst");
    cyc(TMemAddr, "lw_rst_addr");
    cyc(TLwRead, "lw_rst_read");
    reset = 1'b1;
    cyc(TLwWait, "lw_rst_wait");
    reset = 1'b0;
    cyc(TReset, "lw_rst_reset");
    cyc(TFetch, "post_rst_fetch");

    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
